seg_scan_ctrl: RTL and testbench

//  Time-multiplexed scan controller for the calculator's common-anode 7-seg display bank.

---
 rtl/seg_pkg.sv | 39 +++
 rtl/seg_scan_ctrl_if.sv | 24 ++
 rtl/seg_decode.sv | 28 ++
 rtl/seg_scan_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/seg_pkg.sv
// Shared definitions for the 7-segment scan controller: active-low segment
// codes, the scan FSM state type and the leading-zero blank mask helper.
package seg_pkg;

    localparam logic [7:0] SEG_0       = 8'hc0;
    localparam logic [7:0] SEG_1       = 8'hf9;
    localparam logic [7:0] SEG_2       = 8'ha4;
    localparam logic [7:0] SEG_3       = 8'hb0;
    localparam logic [7:0] SEG_4       = 8'h99;
    localparam logic [7:0] SEG_5       = 8'h92;
    localparam logic [7:0] SEG_6       = 8'h82;
    localparam logic [7:0] SEG_7       = 8'hf8;
    localparam logic [7:0] SEG_8       = 8'h80;
    localparam logic [7:0] SEG_9       = 8'h90;
    localparam logic [7:0] SEG_MINUS   = 8'hbf;
    localparam logic [7:0] SEG_BLANK   = 8'hff;
    localparam logic [7:0] SEG_DP_MASK = 8'h7f;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GAP  = 2'd1,
        SHOW = 2'd2
    } scan_state_t;

    // Bit i set when digit i sits above the most significant nonzero nibble.
    // Digit 0 is never blanked so a zero value still shows "0".
    function automatic logic [7:0] lz_blank_mask(input logic [31:0] bcd, input int num_digits);
        logic [7:0] mask;
        logic       seen;
        mask = 8'h00;
        seen = 1'b0;
        for (int i = 7; i >= 1; i--) begin
            seen    = seen | ((i < num_digits) && (bcd[4*i +: 4] != 4'd0));
            mask[i] = (i < num_digits) && !seen;
        end
        return mask;
    endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Load channel of the scan controller: packed BCD value plus decimal points
// offered over a valid/ready handshake.
interface seg_scan_ctrl_if #(
    parameter int NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] bcd_in;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic                    load_valid;
    logic                    load_ready;

    modport master (
        output bcd_in,
        output dp_in,
        output load_valid,
        input  load_ready
    );

    modport slave (
        input  bcd_in,
        input  dp_in,
        input  load_valid,
        output load_ready
    );
endinterface

// File: rtl/seg_decode.sv
// Combinational BCD nibble to active-low 7-segment code (bit7 = dp, left off).
module seg_decode
    import seg_pkg::*;
(
    input  logic [3:0] nib,
    output logic [7:0] seg
);

    // Table lookup; 4'hA is the minus sign, B..F are blank
    always_comb begin
        seg = SEG_BLANK;
        case (nib)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            4'd10:   seg = SEG_MINUS;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode 7-segment bank.
// A loaded value waits in a pending buffer and is swapped into the display
// buffer only at a frame boundary (or from IDLE), so a frame never tears.
// Each digit slot is CLK_DIV cycles: GAP_CYCLES blank, then the digit shown.
// Optional build macro SEG_LZ_BLANK_EN enables leading-zero blanking.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int CLK_DIV    = 50000,
    parameter int GAP_CYCLES = 500
) (
    input  logic                  clk,
    input  logic                  rst,
    seg_scan_ctrl_if.slave        load,
    output logic [7:0]            seg_n,
    output logic [NUM_DIGITS-1:0] dig_n,
    output logic                  frame_done
);

    localparam int              PW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int              IW        = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int              BW        = 4 * NUM_DIGITS;
    localparam logic [PW-1:0]   GAP_LAST  = PW'(GAP_CYCLES - 1);
    localparam logic [PW-1:0]   SLOT_LAST = PW'(CLK_DIV - 1);
    localparam logic [IW-1:0]   IDX_LAST  = IW'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] DIG_ONE  = NUM_DIGITS'(1'b1);
    localparam logic [NUM_DIGITS-1:0] DIG_NONE = {NUM_DIGITS{1'b1}};

    if ((NUM_DIGITS < 1) || (NUM_DIGITS > 8) || (GAP_CYCLES < 1) ||
        (GAP_CYCLES >= CLK_DIV) || (CLK_DIV < 4)) begin : g_bad_params
        $error("seg_scan_ctrl: illegal NUM_DIGITS/CLK_DIV/GAP_CYCLES");
    end

    scan_state_t             state_r, state_nxt_s;
    logic [PW-1:0]           presc_r, presc_nxt_s;
    logic [IW-1:0]           idx_r, idx_nxt_s;
    logic [BW-1:0]           pend_bcd_r, disp_bcd_r, disp_bcd_nxt_s;
    logic [NUM_DIGITS-1:0]   pend_dp_r, disp_dp_r, disp_dp_nxt_s;
    logic [NUM_DIGITS-1:0]   blank_r, blank_nxt_s;
    logic                    pend_vld_r, pend_vld_nxt_s;
    logic                    load_ready_r;
    logic                    accept_s, swap_s, frame_done_nxt_s;
    logic [3:0]              nib_s;
    logic                    dp_s, blk_s;
    logic [7:0]              dec_s, seg_nxt_s;
    logic [NUM_DIGITS-1:0]   dig_nxt_s;

    assign load.load_ready = load_ready_r;
    assign accept_s        = load.load_valid && load_ready_r;

    // Scan sequencing: slot prescaler, digit index and frame boundary detection
    always_comb begin
        state_nxt_s      = state_r;
        presc_nxt_s      = presc_r;
        idx_nxt_s        = idx_r;
        frame_done_nxt_s = 1'b0;
        swap_s           = 1'b0;
        case (state_r)
            IDLE: begin
                if (pend_vld_r) begin
                    state_nxt_s = GAP;
                    presc_nxt_s = {PW{1'b0}};
                    idx_nxt_s   = {IW{1'b0}};
                    swap_s      = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            GAP: begin
                presc_nxt_s = presc_r + PW'(1);
                if (presc_r == GAP_LAST) begin
                    state_nxt_s = SHOW;
                end else begin
                    state_nxt_s = GAP;
                end
            end
            SHOW: begin
                if (presc_r == SLOT_LAST) begin
                    presc_nxt_s = {PW{1'b0}};
                    state_nxt_s = GAP;
                    if (idx_r == IDX_LAST) begin
                        idx_nxt_s        = {IW{1'b0}};
                        frame_done_nxt_s = 1'b1;
                        swap_s           = pend_vld_r;
                    end else begin
                        idx_nxt_s = idx_r + IW'(1);
                    end
                end else begin
                    presc_nxt_s = presc_r + PW'(1);
                end
            end
            default: begin
                state_nxt_s = IDLE;
                presc_nxt_s = {PW{1'b0}};
                idx_nxt_s   = {IW{1'b0}};
            end
        endcase
    end

    // Pending/display buffers; accept and swap never coincide since ready = !pend_vld
    always_comb begin
        disp_bcd_nxt_s = disp_bcd_r;
        disp_dp_nxt_s  = disp_dp_r;
        blank_nxt_s    = blank_r;
        pend_vld_nxt_s = pend_vld_r;
        if (accept_s) begin
            pend_vld_nxt_s = 1'b1;
        end else if (swap_s) begin
            pend_vld_nxt_s = 1'b0;
        end else begin
            pend_vld_nxt_s = pend_vld_r;
        end
        if (swap_s) begin
            disp_bcd_nxt_s = pend_bcd_r;
            disp_dp_nxt_s  = pend_dp_r;
`ifdef SEG_LZ_BLANK_EN
            blank_nxt_s    = NUM_DIGITS'(lz_blank_mask(32'(pend_bcd_r), NUM_DIGITS));
`else
            blank_nxt_s    = {NUM_DIGITS{1'b0}};
`endif
        end else begin
            disp_bcd_nxt_s = disp_bcd_r;
            disp_dp_nxt_s  = disp_dp_r;
        end
    end

    assign nib_s = disp_bcd_nxt_s[{idx_nxt_s, 2'b00} +: 4];
    assign dp_s  = disp_dp_nxt_s[idx_nxt_s];
    assign blk_s = blank_nxt_s[idx_nxt_s];

    seg_decode u_decode (
        .nib (nib_s),
        .seg (dec_s)
    );

    // Next output codes follow the next state so outputs switch with the state
    always_comb begin
        seg_nxt_s = SEG_BLANK;
        dig_nxt_s = DIG_NONE;
        case (state_nxt_s)
            SHOW: begin
                dig_nxt_s = ~(DIG_ONE << idx_nxt_s);
                seg_nxt_s = (blk_s ? SEG_BLANK : dec_s) & (dp_s ? SEG_DP_MASK : SEG_BLANK);
            end
            default: begin
                seg_nxt_s = SEG_BLANK;
                dig_nxt_s = DIG_NONE;
            end
        endcase
    end

    // State, buffers and registered outputs; reset blanks the bank and drops any pending load
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r      <= IDLE;
            presc_r      <= {PW{1'b0}};
            idx_r        <= {IW{1'b0}};
            pend_bcd_r   <= {BW{1'b0}};
            pend_dp_r    <= {NUM_DIGITS{1'b0}};
            pend_vld_r   <= 1'b0;
            disp_bcd_r   <= {BW{1'b0}};
            disp_dp_r    <= {NUM_DIGITS{1'b0}};
            blank_r      <= {NUM_DIGITS{1'b0}};
            load_ready_r <= 1'b1;
            seg_n        <= SEG_BLANK;
            dig_n        <= DIG_NONE;
            frame_done   <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            presc_r      <= presc_nxt_s;
            idx_r        <= idx_nxt_s;
            pend_vld_r   <= pend_vld_nxt_s;
            disp_bcd_r   <= disp_bcd_nxt_s;
            disp_dp_r    <= disp_dp_nxt_s;
            blank_r      <= blank_nxt_s;
            load_ready_r <= !pend_vld_nxt_s;
            seg_n        <= seg_nxt_s;
            dig_n        <= dig_nxt_s;
            frame_done   <= frame_done_nxt_s;
            if (accept_s) begin
                pend_bcd_r <= load.bcd_in;
                pend_dp_r  <= load.dp_in;
            end else begin
                pend_bcd_r <= pend_bcd_r;
                pend_dp_r  <= pend_dp_r;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl (4 digits, 8-cycle slots, 2-cycle gap).
// A timeline model derives every cycle's expected outputs from the time
// elapsed since scanning began and pushes them into a queue; a monitor on
// the falling edge pops and compares against the DUT.
module tb_seg_scan_ctrl;

    localparam int ND    = 4;
    localparam int CD    = 8;
    localparam int GC    = 2;
    localparam int FRAME = ND * CD;
    localparam logic [7:0] SEG_TAB [16] = '{
        8'hc0, 8'hf9, 8'ha4, 8'hb0, 8'h99, 8'h92, 8'h82, 8'hf8,
        8'h80, 8'h90, 8'hbf, 8'hff, 8'hff, 8'hff, 8'hff, 8'hff};

    typedef struct packed {
        logic [7:0]    seg;
        logic [ND-1:0] dig;
        logic          fd;
        logic          rdy;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [7:0]    seg_n;
    logic [ND-1:0] dig_n;
    logic          frame_done;

    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t exp_q[$];

    seg_scan_ctrl_if #(.NUM_DIGITS(ND)) lif ();

    seg_scan_ctrl #(.NUM_DIGITS(ND), .CLK_DIV(CD), .GAP_CYCLES(GC)) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (lif),
        .seg_n      (seg_n),
        .dig_n      (dig_n),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // Reference model: elapsed cycles since scan start fix slot, digit and boundary
    initial begin : model
        logic        run, pend, pend_before;
        logic [15:0] pbcd, dbcd;
        logic [3:0]  pdp, ddp;
        int          t, p, d;
        exp_t        e;
        run = 1'b0; pend = 1'b0; pbcd = 16'h0; dbcd = 16'h0; pdp = 4'h0; ddp = 4'h0; t = 0;
        forever begin
            @(posedge clk);
            pend_before = pend;
            if (!rst) begin
                run = 1'b0; pend = 1'b0; pbcd = 16'h0; dbcd = 16'h0; pdp = 4'h0; ddp = 4'h0; t = 0;
            end else begin
                if (!run) begin
                    if (pend_before) begin
                        run = 1'b1; t = 0; dbcd = pbcd; ddp = pdp; pend = 1'b0;
                    end
                end else begin
                    t++;
                    if ((t % FRAME == 0) && pend_before) begin
                        dbcd = pbcd; ddp = pdp; pend = 1'b0;
                    end
                end
                if (lif.load_valid && !pend_before) begin
                    pend = 1'b1; pbcd = lif.bcd_in; pdp = lif.dp_in;
                end
            end
            e.seg = 8'hff;
            e.dig = 4'hf;
            e.fd  = 1'b0;
            e.rdy = !pend;
            if (run) begin
                p    = t % CD;
                d    = (t / CD) % ND;
                e.fd = (t > 0) && (t % FRAME == 0);
                if (p >= GC) begin
                    e.dig    = 4'hf;
                    e.dig[d] = 1'b0;
                    e.seg    = SEG_TAB[(dbcd >> (4 * d)) & 16'hf];
`ifdef SEG_LZ_BLANK_EN
                    if ((d > 0) && ((dbcd >> (4 * d)) == 16'h0)) e.seg = 8'hff;
`endif
                    if (ddp[d]) e.seg = e.seg & 8'h7f;
                end
            end
            exp_q.push_back(e);
        end
    end

    // Monitor: compare each registered output set against the model's prediction
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_checks++;
                if ({seg_n, dig_n, frame_done, lif.load_ready} === e) begin
                    n_pass++;
                end else begin
                    $display("FAIL scan_out t=%0t seg=%h want %h dig=%b want %b fd=%b want %b rdy=%b want %b",
                             $time, seg_n, e.seg, dig_n, e.dig, frame_done, e.fd, lif.load_ready, e.rdy);
                end
            end
        end
    end

    // Offer one value and hold it until the controller takes it (bounded)
    task automatic do_load(input logic [15:0] b, input logic [3:0] dp);
        int   n;
        logic r;
        lif.bcd_in     = b;
        lif.dp_in      = dp;
        lif.load_valid = 1'b1;
        n = 0;
        do begin
            r = lif.load_ready;
            @(negedge clk);
            n++;
        end while (!r && n < 300);
        lif.load_valid = 1'b0;
        n_checks++;
        if (r) n_pass++;
        else $display("FAIL load_accept value=%h accepted=%b want 1", b, r);
    endtask

    // Wait (bounded) until the given digit select pattern is shown
    task automatic wait_dig(input logic [ND-1:0] want, input logic need_busy);
        int n;
        n = 0;
        while (!((dig_n == want) && (!need_busy || !lif.load_ready)) && n < 300) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (n < 300) n_pass++;
        else $display("FAIL wait_dig dig=%b want %b", dig_n, want);
    endtask

    initial begin : stim
        lif.load_valid = 1'b0;
        lif.bcd_in     = 16'h0;
        lif.dp_in      = 4'h0;
        rst            = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (10) @(negedge clk);
        do_load(16'h1234, 4'b0000);
        repeat (80) @(negedge clk);
        do_load(16'h5678, 4'b0000);
        do_load(16'h9999, 4'b1111);
        repeat (100) @(negedge clk);
        do_load(16'hA005, 4'b0010);
        repeat (70) @(negedge clk);
        do_load(16'h0050, 4'b0000);
        repeat (70) @(negedge clk);
        do_load(16'h0000, 4'b0000);
        repeat (70) @(negedge clk);
        for (int i = 0; i < 12; i++) begin
            do_load(16'($urandom), 4'($urandom));
            repeat ($urandom_range(1, 60)) @(negedge clk);
        end
        repeat (80) @(negedge clk);
        wait_dig(4'b1110, 1'b0);
        do_load(16'h8642, 4'b0101);
        wait_dig(4'b1011, 1'b1);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (40) @(negedge clk);
        do_load(16'h4321, 4'b1000);
        repeat (70) @(negedge clk);
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
